// File: rtl/serial_pkg.sv
// Shared encodings for the serial link tx/rx FSMs.
// Commands, FSM states and default word width.
package serial_pkg;

  localparam int DATA_WIDTH_BASE_DEF = 5;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_START = 2'd1,
    CMD_RSVD  = 2'd2,
    CMD_ABORT = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BIT = 2'd1,
    LATCH    = 2'd2,
    ERR      = 2'd3
  } state_e;

endpackage

// File: rtl/serial_sync.sv
// STAGES-deep synchroniser with registered rising edge.
// Ports: clk, rst (async low), d in; q sync level, rise pulse.
module serial_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] s;

  // rise is registered from the stage before q so it
  // lines up with the first cycle q reads high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s    <= '0;
      rise <= 1'b0;
    end else begin
      s    <= {s[STAGES-2:0], d};
      rise <= s[STAGES-2] & ~s[STAGES-1];
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/rx_fsm.sv
// Serial receiver: shifts MSB-first bits on sck edges,
// commits on latch strobe. Ports: clk, rst, state_in,
// sck_rx/data_rx/latch_rx in; received_data, data_valid,
// busy, error, finish_fsm out (all registered).
module rx_fsm
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH_BASE = DATA_WIDTH_BASE_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    state_in,
  input  logic                          sck_rx,
  input  logic                          data_rx,
  input  logic                          latch_rx,
  output logic [2**DATA_WIDTH_BASE-1:0] received_data,
  output logic                          data_valid,
  output logic                          busy,
  output logic                          error,
  output logic                          finish_fsm
);

  localparam int W  = 2**DATA_WIDTH_BASE;
  localparam int CW = DATA_WIDTH_BASE + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  state_e        state;
  logic [W-1:0]  shift;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] tmo;

  logic sck_s, sck_rise;
  logic data_s, data_rise;
  logic latch_s, latch_rise;
  logic unused_rise;

  assign unused_rise = data_rise ^ latch_rise ^ sck_s;

  serial_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk  (clk),
    .rst  (rst),
    .d    (sck_rx),
    .q    (sck_s),
    .rise (sck_rise)
  );

  serial_sync #(.STAGES(SYNC_STAGES)) u_data (
    .clk  (clk),
    .rst  (rst),
    .d    (data_rx),
    .q    (data_s),
    .rise (data_rise)
  );

  serial_sync #(.STAGES(SYNC_STAGES)) u_latch (
    .clk  (clk),
    .rst  (rst),
    .d    (latch_rx),
    .q    (latch_s),
    .rise (latch_rise)
  );

  logic is_start, is_abort;
  assign is_start = (state_in == CMD_START);
  assign is_abort = (state_in == CMD_ABORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      tmo           <= '0;
      received_data <= '0;
      data_valid    <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      finish_fsm    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      finish_fsm <= 1'b0;
      if (is_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (is_start) begin
              state   <= WAIT_BIT;
              busy    <= 1'b1;
              bit_cnt <= '0;
              tmo     <= '0;
              error   <= 1'b0;
            end
          end
          WAIT_BIT: begin
            if (sck_rise) begin
              shift   <= {shift[W-2:0], data_s};
              bit_cnt <= bit_cnt + 1'b1;
              tmo     <= '0;
              if (bit_cnt == LAST_BIT) begin
                state <= LATCH;
              end
            end else if (bit_cnt != '0) begin
              // no timeout until the frame has begun
              if (tmo == TMO_MAX) begin
                state <= ERR;
              end else begin
                tmo <= tmo + 1'b1;
              end
            end
          end
          LATCH: begin
            // overrun edge beats a simultaneous latch
            if (sck_rise) begin
              state <= ERR;
            end else if (latch_s) begin
              received_data <= shift;
              data_valid    <= 1'b1;
              finish_fsm    <= 1'b1;
              state         <= IDLE;
              busy          <= 1'b0;
            end else if (tmo == TMO_MAX) begin
              state <= ERR;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          ERR: begin
            error      <= 1'b1;
            finish_fsm <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_fsm.sv
// Bench for rx_fsm: frame table plus abort/reset cases.
// Scoreboard queue checks every data_valid word.
module tb_rx_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  state_in = 2'd0;
  logic        sck_rx = 1'b0;
  logic        data_rx = 1'b0;
  logic        latch_rx = 1'b0;
  logic [31:0] received_data;
  logic        data_valid;
  logic        busy;
  logic        error;
  logic        finish_fsm;

  rx_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .state_in      (state_in),
    .sck_rx        (sck_rx),
    .data_rx       (data_rx),
    .latch_rx      (latch_rx),
    .received_data (received_data),
    .data_valid    (data_valid),
    .busy          (busy),
    .error         (error),
    .finish_fsm    (finish_fsm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;
  int fin_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word = 32'h0;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          extra;
    bit          tmo;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (finish_fsm) fin_cnt++;
      if (data_valid) begin
        dv_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_extra: got %h want none",
                   received_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (received_data !== e) begin
            fails++;
            $display("FAIL sb_word: got %h want %h",
                     received_data, e);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cmd(input logic [1:0] c);
    @(negedge clk);
    state_in = c;
    @(negedge clk);
    state_in = 2'd0;
  endtask

  task automatic send_bits(input logic [31:0] w,
                           input int n);
    for (int i = 0; i < n; i++) begin
      data_rx = w[31-i];
      repeat (4) @(negedge clk);
      sck_rx = 1'b1;
      repeat (4) @(negedge clk);
      sck_rx = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int dv0, f0;
    dv0 = dv_cnt;
    f0  = fin_cnt;
    cmd(2'd1);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d_errclr", idx), 32'(error), 32'd0);
    if (!v.exp_err) exp_q.push_back(v.word);
    send_bits(v.word, v.nbits);
    if (v.extra) send_bits(32'h8000_0000, 1);
    if (v.tmo) begin
      repeat (80) @(negedge clk);
    end else begin
      latch_rx = 1'b1;
      repeat (6) @(negedge clk);
      latch_rx = 1'b0;
    end
    repeat (10) @(negedge clk);
    if (!v.exp_err) last_word = v.word;
    chk($sformatf("v%0d_dv", idx), 32'(dv_cnt - dv0),
        v.exp_err ? 32'd0 : 32'd1);
    chk($sformatf("v%0d_fin", idx), 32'(fin_cnt - f0), 32'd1);
    chk($sformatf("v%0d_err", idx), 32'(error),
        32'(v.exp_err));
    chk($sformatf("v%0d_data", idx), received_data, last_word);
    chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    int f0;
    vecs[0] = '{32'h56D0_1953, 32, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hBEEF_0000, 16, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h1234_5678, 32, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'hA5A5_A5A5, 32, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h5A5A_5A5A, 32, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_data", received_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_fin", 32'(finish_fsm), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // abort mid-frame
    f0 = fin_cnt;
    cmd(2'd1);
    send_bits(32'hFFFF_FFFF, 10);
    @(negedge clk);
    state_in = 2'd3;
    @(negedge clk);
    state_in = 2'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_fin", 32'(fin_cnt - f0), 32'd0);
    chk("abort_err", 32'(error), 32'd0);
    chk("abort_data", received_data, last_word);
    v = '{32'hFFFF_FFFF, 32, 1'b0, 1'b0, 1'b0};
    run_vec(v, 5);

    // async reset mid-frame
    cmd(2'd1);
    send_bits(32'hFFFF_FFFF, 20);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_data", received_data, 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(error), 32'd0);
    chk("arst_dv", 32'(data_valid), 32'd0);
    chk("arst_fin", 32'(finish_fsm), 32'd0);
    last_word = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    v = '{32'h0000_0001, 32, 1'b0, 1'b0, 1'b0};
    run_vec(v, 6);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_fsm.md
Name: rx_fsm

Overview:
Serial receiver FSM for the full-duplex serial link. It is the receiving end of the frame that tx_fsm sends: serial clock, data line and latch strobe.
- Samples 2**DATA_WIDTH_BASE bits, MSB first, on rising edges of the incoming serial clock.
- Commits the word on the latch strobe and reports completion to the control logic.
- Link signals are asynchronous to clk and are synchronised internally.

Parameters:
DATA_WIDTH_BASE, 5, log2 of word width (word = 32 bits)
SYNC_STAGES, 2, flip-flop stages on sck_rx, data_rx and latch_rx (min 2)
TIMEOUT_CYCLES, 64, clk cycles without an sck edge mid-frame before error

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
state_in  input  2  command: 0 NOP, 1 START (arm receive), 2 reserved (treated as NOP), 3 ABORT
sck_rx  input  1  serial clock from remote transmitter
data_rx  input  1  serial data, valid at sck_rx rising edge
latch_rx  input  1  frame-commit strobe from remote, level-sampled
received_data  output  2**DATA_WIDTH_BASE  last committed word
data_valid  output  1  one-cycle pulse when received_data updates
busy  output  1  high in any state other than IDLE
error  output  1  sticky frame error, cleared by START or reset
finish_fsm  output  1  one-cycle pulse on frame end, good or bad

Behaviour:
- Reset (rst low, async):
  - state = IDLE; received_data, shift register, bit counter and timeout counter = 0.
  - data_valid, busy, error and finish_fsm = 0; synchroniser flops = 0.
- Synchronisation:
  - sck_rx, data_rx and latch_rx each pass through SYNC_STAGES flops.
  - Rising edge = sync sck high and previous sync sck low.
  - data is taken from the same sync stage depth as sck, so bit alignment is preserved.
  - Pin-to-shift latency is SYNC_STAGES+1 clk.
  - sck high and low times must each be at least SYNC_STAGES+1 clk periods. Faster input is unsupported.
- IDLE: START -> WAIT_BIT; clears bit counter, timeout counter and error. Other commands are ignored.
- WAIT_BIT:
  - On each sck rising edge: shift <= {shift[W-2:0], data_sync}, bit counter++, timeout counter cleared.
  - When the counter reaches W on that edge -> LATCH.
  - Otherwise the timeout counter increments every clk, but only once at least 1 bit has been received.
  - Timeout counter == TIMEOUT_CYCLES -> ERR.
  - No timeout applies before the first bit, so the block can wait indefinitely for the frame to start.
- LATCH:
  - latch_rx sync high -> received_data <= shift, data_valid = 1 and finish_fsm = 1 for 1 clk, -> IDLE.
  - sck rising edge while in LATCH -> ERR (overrun); received_data is not updated.
  - Timeout counter runs from entry; TIMEOUT_CYCLES -> ERR.
- ERR: error <= 1, finish_fsm = 1 for 1 clk, -> IDLE. received_data is unchanged.
- ABORT in any state -> IDLE next clk:
  - no data_valid and no finish_fsm pulse; error is unchanged.
  - ABORT takes priority over simultaneous edge, latch or timeout events.
- START while busy is ignored.
- Simultaneous latch_rx high and sck edge in LATCH: the sck edge wins -> ERR.
- received_data holds its value between frames.
- The bit counter is DATA_WIDTH_BASE+1 bits wide and never wraps within a frame.

Decomposition:
- Shared package (serial_pkg): command encodings (CMD_NOP=0, CMD_START=1, CMD_ABORT=3), state encodings (IDLE, WAIT_BIT, LATCH, ERR), DATA_WIDTH_BASE default.
- tx_fsm uses the same command encodings.
- One sub-module: serial_sync, a SYNC_STAGES-deep synchroniser with a registered rising-edge output, instantiated for sck and reused for data and latch.

Test Plan:
1. Reset low then high, START, send 0x56D01953 MSB first, then latch -> data_valid pulse once, received_data = 0x56D01953, finish_fsm once, error 0.
2. START, 16 bits, then sck held 80 clk -> error 1, finish_fsm once, no data_valid, received_data keeps its previous value.
3. START, 32 bits, then an extra sck edge before latch -> ERR; error 1, received_data unchanged.
4. START, 10 bits, ABORT -> busy 0 next clk, no finish_fsm; a following START plus a full frame of 0xFFFFFFFF receives correctly.
5. rst pulsed low mid-frame (bit 20) -> all outputs 0 asynchronously; a new START plus frame 0x00000001 is received correctly.
6. Two back-to-back frames 0xA5A5A5A5 and 0x5A5A5A5A with START after each finish -> two data_valid pulses and correct values in order.
